// File: rtl/pipeline_sequencer.sv
// Hazard/flush sequencer with terminator-driven drain and halt; optional stall
// counter enabled by PIPELINE_SEQUENCER_STALL_COUNT_EN.
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_wreg,
    input  logic        id_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       halted_q;
    logic       terminator;
    logic       load_use;

    assign terminator = (id_instr == 32'hFFFF_FFFF);
    assign load_use   = ex_memRead && (ex_wreg != 5'd0) &&
                        ((ex_wreg == id_instr[25:21]) || (ex_wreg == id_instr[20:16]));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (terminator) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = DRAIN_INIT;
                end else if (load_use) begin
                    // Stall beats a taken branch; the branch re-resolves next cycle.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_branch_taken) begin
                    ifid_flush  = 1'b1;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALT);
        end
    end

    assign halted = halted_q;

`ifdef PIPELINE_SEQUENCER_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = (state_q == RUN) && !terminator && load_use;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: driver queues expected outputs per cycle,
// monitor pops and compares mid low phase.
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        ex_memRead;
    logic [4:0]  ex_wreg;
    logic        id_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, halted;
    logic [31:0] stall_count;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        bub;
        logic        hlt;
        logic [31:0] sc;
        string       nm;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_sc = 32'd0;

    localparam logic [31:0] NOP_I  = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] RS8_I  = 32'h010A_4820; // add $9,$8,$10
    localparam logic [31:0] RT8_I  = 32'h0028_4820; // add $9,$1,$8
    localparam logic [31:0] ZERO_I = 32'h0000_0020; // add $0,$0,$0
    localparam logic [31:0] TERM_I = 32'hFFFF_FFFF;

    pipeline_sequencer #(.DRAIN_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_instr        (id_instr),
        .ex_memRead      (ex_memRead),
        .ex_wreg         (ex_wreg),
        .id_branch_taken (id_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] ins, input logic mr,
                        input logic [4:0] w, input logic br,
                        input logic pcw, input logic ifw, input logic fl,
                        input logic bub, input logic hlt, input logic stall,
                        input string nm);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        id_instr        = ins;
        ex_memRead      = mr;
        ex_wreg         = w;
        id_branch_taken = br;
        if (rst) model_sc = 32'd0;
        e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.hlt = hlt;
        e.sc  = model_sc; e.nm = nm;
        expq.push_back(e);
`ifdef PIPELINE_SEQUENCER_STALL_COUNT_EN
        if (stall && !rst && model_sc != 32'hFFFF_FFFF) model_sc = model_sc + 32'd1;
`else
        if (stall && !rst) model_sc = 32'd0;
`endif
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk({e.nm, ".pc_write"},    {31'd0, pc_write},    {31'd0, e.pcw});
                chk({e.nm, ".ifid_write"},  {31'd0, ifid_write},  {31'd0, e.ifw});
                chk({e.nm, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, e.fl});
                chk({e.nm, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, e.bub});
                chk({e.nm, ".halted"},      {31'd0, halted},      {31'd0, e.hlt});
                chk({e.nm, ".stall_count"}, stall_count,          e.sc);
            end
        end
    end

    // Driver: args are rst, instr, memRead, wreg, br | pcw, ifw, flush, bubble, halted, stall
    initial begin
        reset = 1'b1; id_instr = NOP_I; ex_memRead = 1'b0; ex_wreg = 5'd0; id_branch_taken = 1'b0;
        step(1, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "reset0");
        step(1, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "reset1");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "idle");
        step(0, RS8_I, 1, 8, 0,  0, 0, 0, 1, 0, 1, "lu_rs");
        step(0, RS8_I, 0, 8, 0,  1, 1, 0, 0, 0, 0, "lu_after");
        step(0, RT8_I, 1, 8, 0,  0, 0, 0, 1, 0, 1, "lu_rt");
        step(0, ZERO_I, 1, 0, 0, 1, 1, 0, 0, 0, 0, "wreg0");
        step(0, NOP_I, 1, 5, 0,  1, 1, 0, 0, 0, 0, "no_match");
        step(0, NOP_I, 0, 0, 1,  1, 1, 1, 0, 0, 0, "branch");
        step(0, RS8_I, 1, 8, 1,  0, 0, 0, 1, 0, 1, "br_vs_lu");
        step(0, RS8_I, 0, 8, 1,  1, 1, 1, 0, 0, 0, "br_retry");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "idle2");
        // rs=rt=31 in the terminator word also matches wreg 31; terminator must win.
        step(0, TERM_I, 1, 31, 1, 0, 0, 0, 1, 0, 0, "term");
        for (int i = 0; i < 4; i++)
            step(0, RS8_I, 1, 8, i[0], 0, 0, 0, 1, 0, 0, "drain");
        for (int i = 0; i < 21; i++)
            step(0, (i[1] ? TERM_I : RS8_I), i[0], 8, i[2], 0, 0, 0, 1, 1, 0, "halt");
        step(1, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "rst_halt");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "run_again");
        step(0, TERM_I, 0, 0, 0, 0, 0, 0, 1, 0, 0, "term2");
        step(0, NOP_I, 0, 0, 0,  0, 0, 0, 1, 0, 0, "drain2_1");
        step(1, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "rst_in_drain");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "after_abort");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "after_abort2");
        step(0, TERM_I, 0, 0, 0, 0, 0, 0, 1, 0, 0, "term3");
        for (int i = 0; i < 4; i++)
            step(0, NOP_I, 0, 0, 0, 0, 0, 0, 1, 0, 0, "drain3");
        step(0, NOP_I, 0, 0, 0,  0, 0, 0, 1, 1, 0, "halt3");
        step(0, NOP_I, 0, 0, 0,  0, 0, 0, 1, 1, 0, "halt3b");
`ifdef PIPELINE_SEQUENCER_STALL_COUNT_EN
        step(1, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "rst_sat");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "pre_sat");
        @(posedge clk);
        #1;
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        model_sc = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++)
            step(0, RS8_I, 1, 8, 0, 0, 0, 0, 1, 0, 1, "sat_lu");
        step(0, NOP_I, 0, 0, 0,  1, 1, 0, 0, 0, 0, "sat_hold");
`endif
        @(negedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
